// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined Hack-style ALU.
// Stage 1 applies the zero/negate preprocessing to the operands.
// Stage 2 evaluates the function selected by {fmode,f}, applies output
// negation, and registers the result together with its flags.
// Both stages use valid/ready handshaking, so the block runs at one
// operation per cycle and stalls safely under backpressure.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctl,
  input  logic             fmode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] o,
  output logic             ng,
  output logic             zr,
  output logic             cy,
  output logic             ov,
  output logic [CNT_W-1:0] op_count
);

  localparam int MSB = WIDTH - 1;

  // Stage 1 registers
  logic             s1_valid_q;
  logic [WIDTH-1:0] xp_q, yp_q;
  logic             f_q, no_q, fmode_q;

  // Stage 2 registers
  logic             s2_valid_q;
  logic [WIDTH-1:0] o_q;
  logic             ng_q, zr_q, cy_q, ov_q;
  logic [CNT_W-1:0] op_count_q;

  // Handshake signals
  logic s2_ready, s1_adv, in_xfer, out_xfer;

  // Next-state values
  logic [WIDTH-1:0] xp_d, yp_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r_d, o_d;
  logic             add_sel, cy_d, ov_d;

  // Stage 2 can take new data when empty or when its current result leaves.
  assign s2_ready = ~s2_valid_q | out_ready;
  assign s1_adv   = s1_valid_q & s2_ready;
  assign in_ready = ~s1_valid_q | s2_ready;
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = s2_valid_q & out_ready;

  // Operand preprocessing: optional zeroing, then optional bitwise invert.
  always_comb begin
    xp_d = ctl[5] ? '0 : x;
    if (ctl[4]) xp_d = ~xp_d;
    yp_d = ctl[3] ? '0 : y;
    if (ctl[2]) yp_d = ~yp_d;
  end

  // Function evaluation; carry and overflow come from the adder only and
  // are taken before the output negation.
  always_comb begin
    sum     = {1'b0, xp_q} + {1'b0, yp_q};
    add_sel = ~fmode_q & f_q;
    case ({fmode_q, f_q})
      2'b00:   r_d = xp_q & yp_q;
      2'b01:   r_d = sum[WIDTH-1:0];
      2'b10:   r_d = xp_q | yp_q;
      default: r_d = xp_q ^ yp_q;
    endcase
    o_d  = no_q ? ~r_d : r_d;
    cy_d = add_sel & sum[WIDTH];
    ov_d = add_sel & (xp_q[MSB] == yp_q[MSB]) & (sum[MSB] != xp_q[MSB]);
  end

  // Stage 1: capture preprocessed operands on accept, empty when drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      xp_q       <= '0;
      yp_q       <= '0;
      f_q        <= 1'b0;
      no_q       <= 1'b0;
      fmode_q    <= 1'b0;
    end else begin
      if (in_xfer)     s1_valid_q <= 1'b1;
      else if (s1_adv) s1_valid_q <= 1'b0;
      if (in_xfer) begin
        xp_q    <= xp_d;
        yp_q    <= yp_d;
        f_q     <= ctl[1];
        no_q    <= ctl[0];
        fmode_q <= fmode;
      end
    end
  end

  // Stage 2: register result and flags on advance, hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      o_q        <= '0;
      ng_q       <= 1'b0;
      zr_q       <= 1'b0;
      cy_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      if (s1_adv)        s2_valid_q <= 1'b1;
      else if (out_xfer) s2_valid_q <= 1'b0;
      if (s1_adv) begin
        o_q  <= o_d;
        ng_q <= o_d[MSB];
        zr_q <= (o_d == '0);
        cy_q <= cy_d;
        ov_q <= ov_d;
      end
    end
  end

  // Completed-operation counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           op_count_q <= '0;
    else if (out_xfer) op_count_q <= op_count_q + CNT_W'(1);
  end

  assign out_valid = s2_valid_q;
  assign o         = o_q;
  assign ng        = ng_q;
  assign zr        = zr_q;
  assign cy        = cy_q;
  assign ov        = ov_q;
  assign op_count  = op_count_q;

endmodule
